// File: rtl/mul4_scheduler_pkg.sv
// Shared types and constants for the two-requester shift-add multiplier scheduler.
package mul4_sched_pkg;

    localparam int BITS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/mul4_scheduler_if.sv
// Request/response bundle between two requesters, one consumer and the multiplier scheduler.
interface mul4_scheduler_if import mul4_sched_pkg::*; #(
    parameter int BITS = BITS_DEFAULT
);
    logic              req0_valid;
    logic [BITS-1:0]   req0_a;
    logic [BITS-1:0]   req0_b;
    logic              req0_ready;
    logic              req1_valid;
    logic [BITS-1:0]   req1_a;
    logic [BITS-1:0]   req1_b;
    logic              req1_ready;
    logic              rsp_valid;
    req_id_t           rsp_id;
    logic [2*BITS-1:0] rsp_p;
    logic              rsp_ready;
    logic              busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, busy
    );

endinterface

// File: rtl/mul4_shift_add_core.sv
// Shift-add datapath: one multiplier bit per step, product held in the accumulator.
// Latency: BITS steps after start; no backpressure, the controller gates step.
module mul4_shift_add_core import mul4_sched_pkg::*; #(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [BITS-1:0]   i_a,
    input  logic [BITS-1:0]   i_b,
    input  logic              i_step,
    output logic              o_last,
    output logic [2*BITS-1:0] o_p
);
    localparam int             CW       = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(BITS - 1);

    logic [BITS-1:0]   r_a;
    logic [BITS-1:0]   r_b;
    logic [2*BITS-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic [2*BITS-1:0] w_partial;

    always_comb begin
        w_partial = '0;
        if (r_b[r_cnt]) begin
            w_partial = {{BITS{1'b0}}, r_a} << r_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= r_acc + w_partial;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_last = (r_cnt == LAST_CNT);
    assign o_p    = r_acc;

endmodule

// File: rtl/mul4_scheduler.sv
// Round-robin arbiter + IDLE/RUN/DONE FSM around a shift-add multiplier (MUL4_SCHED_FAST_ZERO_EN: zero operands skip RUN).
// Latency: rsp_valid rises BITS edges after accept (1 edge for zero operands with fast-zero).
// Backpressure: DONE holds product and id until rsp_ready; requesters see ready low outside IDLE.
module mul4_scheduler import mul4_sched_pkg::*; #(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    mul4_scheduler_if.slave   bus
);
    state_t            r_state;
    logic              r_last_grant;
    req_id_t           r_id;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic [BITS-1:0]   w_a;
    logic [BITS-1:0]   w_b;
    logic              w_step;
    logic              w_last;
    logic [2*BITS-1:0] w_prod;
`ifdef MUL4_SCHED_FAST_ZERO_EN
    logic              w_zero;
`endif

    // Contention goes to whichever requester did not win last time.
    always_comb begin
        w_gnt0   = bus.req0_valid && (!bus.req1_valid || r_last_grant);
        w_gnt1   = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        w_accept = (r_state == IDLE) && (w_gnt0 || w_gnt1);
        w_a      = w_gnt1 ? bus.req1_a : bus.req0_a;
        w_b      = w_gnt1 ? bus.req1_b : bus.req0_b;
        w_step   = (r_state == RUN);
    end

`ifdef MUL4_SCHED_FAST_ZERO_EN
    assign w_zero = (w_a == '0) || (w_b == '0);
`endif

    mul4_shift_add_core #(.BITS(BITS)) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_step  (w_step),
        .o_last  (w_last),
        .o_p     (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
`ifdef MUL4_SCHED_FAST_ZERO_EN
                        r_state      <= w_zero ? DONE : RUN;
`else
                        r_state      <= RUN;
`endif
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = !rst && (r_state == IDLE) && w_gnt0;
    assign bus.req1_ready = !rst && (r_state == IDLE) && w_gnt1;
    assign bus.rsp_valid  = (r_state == DONE);
    assign bus.rsp_p      = (r_state == DONE) ? w_prod : '0;
    assign bus.rsp_id     = (r_state == DONE) ? r_id : 1'b0;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mul4_scheduler.sv
// Bench for mul4_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_mul4_scheduler;
    import mul4_sched_pkg::*;

    localparam int BITS = 4;
`ifdef MUL4_SCHED_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   model_last = 1;

    mul4_scheduler_if #(.BITS(BITS)) bus();

    mul4_scheduler #(.BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int a, input int b);
        return (FAST && (a == 0 || b == 0)) ? 1 : BITS;
    endfunction

    function automatic int exp_grant(input bit v0, input bit v1);
        if (v0 && v1) return 1 - model_last;
        return v1 ? 1 : 0;
    endfunction

    task automatic set_req(input int r, input bit v, input int a, input int b);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_a = a[BITS-1:0]; bus.req0_b = b[BITS-1:0];
        end else begin
            bus.req1_valid = v; bus.req1_a = a[BITS-1:0]; bus.req1_b = b[BITS-1:0];
        end
    endtask

    task automatic wait_accept(output int who, output bit to);
        who = -1;
        to  = 1'b1;
        for (int i = 0; i < 64 && to; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                to  = 1'b0;
                who = bus.req1_ready ? 1 : 0;
            end
        end
        if (!to) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 64 && to; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rsp_valid) to = 1'b0;
        end
    endtask

    // Accept one request, drop its valid, wait for the product; the handshake is left to the caller.
    task automatic serve(input int eg, output int who, output int lat, output int p, output int id,
                         output bit to);
        bit t1, t2;
        lat = -1; p = -1; id = -1; t2 = 1'b0;
        wait_accept(who, t1);
        model_last = eg;
        if (!t1) begin
            set_req(who, 1'b0, 0, 0);
            wait_rsp(lat, t2);
            p  = int'(bus.rsp_p);
            id = int'(bus.rsp_id);
        end
        to = t1 | t2;
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 5, 5);
        set_req(1, 1'b1, 6, 6);
        #12;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.busy} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b id=%b p=%0d busy=%b exp all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.busy);
        end
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b%b exp 00", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant got %b%b exp 10", bus.req0_ready, bus.req1_ready);
        end
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
    endtask

    task automatic test_max();
        int who, lat, p, id; bit to;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 15, 15);
        serve(0, who, lat, p, id, to);
        checks++;
        if (to || who !== 0) begin errors++; $display("FAIL max_grant got %0d to=%0d exp 0", who, to); end
        checks++;
        if (lat !== BITS) begin errors++; $display("FAIL max_latency got %0d exp %0d", lat, BITS); end
        checks++;
        if (p !== 225 || id !== 0) begin errors++; $display("FAIL max_product got p=%0d id=%0d exp 225 0", p, id); end
        handshake();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL max_idle got busy=%b exp 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int who, lat, p, id, eg; bit to;
        int ea[3] = '{3, 7, 0};
        int eb[3] = '{5, 9, 0};
        pulse_reset();
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 3, 5);
        set_req(1, 1'b1, 7, 9);
        for (int k = 0; k < 2; k++) begin
            eg = exp_grant(bus.req0_valid, bus.req1_valid);
            serve(eg, who, lat, p, id, to);
            checks++;
            if (to || who !== k || eg !== k) begin
                errors++; $display("FAIL rr_grant%0d got %0d exp %0d", k, who, k);
            end
            checks++;
            if (p !== ea[k] * eb[k] || id !== k) begin
                errors++; $display("FAIL rr_product%0d got p=%0d id=%0d exp %0d %0d", k, p, id, ea[k]*eb[k], k);
            end
            handshake();
        end
        ea[0] = $urandom_range(0, 15); eb[0] = $urandom_range(0, 15);
        ea[1] = $urandom_range(0, 15); eb[1] = $urandom_range(0, 15);
        set_req(0, 1'b1, ea[0], eb[0]);
        set_req(1, 1'b1, ea[1], eb[1]);
        for (int k = 0; k < 2; k++) begin
            eg = exp_grant(bus.req0_valid, bus.req1_valid);
            serve(eg, who, lat, p, id, to);
            checks++;
            if (to || who !== eg || p !== ea[eg] * eb[eg] || id !== eg) begin
                errors++; $display("FAIL rr_third%0d got who=%0d p=%0d exp who=%0d p=%0d", k, who, p, eg, ea[eg]*eb[eg]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int who, lat, p, id, eg; bit to;
        logic [2*BITS-1:0] p0;
        logic id0;
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 13, 6);
        serve(0, who, lat, p, id, to);
        set_req(1, 1'b1, 4, 4);
        checks++;
        if (to || p !== 78 || id !== 0) begin
            errors++; $display("FAIL bp_product got p=%0d id=%0d exp 78 0", p, id);
        end
        p0  = bus.rsp_p;
        id0 = bus.rsp_id;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready} !== 4'b1100 ||
                bus.rsp_p !== p0 || bus.rsp_id !== id0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b busy=%b rdy=%b%b p=%0d id=%b exp 1 1 00 %0d %b", c,
                         bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp_p, bus.rsp_id, p0, id0);
            end
        end
        handshake();
        checks++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL bp_release got v=%b busy=%b exp 0 0", bus.rsp_valid, bus.busy);
        end
        eg = exp_grant(1'b0, 1'b1);
        serve(eg, who, lat, p, id, to);
        checks++;
        if (to || who !== 1 || p !== 16 || id !== 1) begin
            errors++; $display("FAIL bp_next got who=%0d p=%0d id=%0d exp 1 16 1", who, p, id);
        end
        handshake();
    endtask

    task automatic test_reset_abort();
        int who, lat, p, id, seen; bit to;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 12, 11);
        wait_accept(who, to);
        set_req(0, 1'b0, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.busy, bus.req0_ready, bus.req1_ready} !== 13'd0) begin
            errors++;
            $display("FAIL abort_outputs got v=%b id=%b p=%0d busy=%b exp all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d active cycles exp 0", seen); end
        set_req(1, 1'b1, 2, 3);
        serve(1, who, lat, p, id, to);
        checks++;
        if (to || who !== 1 || p !== 6 || id !== 1 || lat !== BITS) begin
            errors++; $display("FAIL abort_next got who=%0d p=%0d id=%0d lat=%0d exp 1 6 1 %0d", who, p, id, lat, BITS);
        end
        handshake();
    endtask

    task automatic test_zero();
        int who, lat, p, id; bit to;
        int za[3] = '{9, 0, 0};
        int zb[3] = '{0, 7, 0};
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(k % 2, 1'b1, za[k], zb[k]);
            serve(k % 2, who, lat, p, id, to);
            checks++;
            if (to || lat !== exp_lat(za[k], zb[k]) || p !== 0 || id !== k % 2) begin
                errors++;
                $display("FAIL zero%0d got lat=%0d p=%0d id=%0d exp %0d 0 %0d", k, lat, p, id, exp_lat(za[k], zb[k]), k % 2);
            end
            handshake();
        end
    endtask

    task automatic test_sweep();
        int who, lat, p, id, r; bit to;
        bus.rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                r = (a * 16 + b) % 2;
                set_req(r, 1'b1, a, b);
                serve(r, who, lat, p, id, to);
                checks++;
                if (to || p !== a * b || id !== r || who !== r || lat !== exp_lat(a, b)) begin
                    errors++;
                    $display("FAIL sweep a=%0d b=%0d got p=%0d id=%0d lat=%0d exp %0d %0d %0d",
                             a, b, p, id, lat, a * b, r, exp_lat(a, b));
                end
                handshake();
            end
        end
    endtask

    task automatic test_random();
        int who, lat, p, id, eg, k; bit to;
        bit pend[2] = '{1'b0, 1'b0};
        int pa[2];
        int pb[2];
        for (int it = 0; it < 80; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1; pa[r] = $urandom_range(0, 15); pb[r] = $urandom_range(0, 15);
                end
            end
            if (!pend[0] && !pend[1]) begin
                k = $urandom_range(0, 1);
                pend[k] = 1'b1; pa[k] = $urandom_range(0, 15); pb[k] = $urandom_range(0, 15);
            end
            set_req(0, pend[0], pa[0], pb[0]);
            set_req(1, pend[1], pa[1], pb[1]);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            eg = exp_grant(pend[0], pend[1]);
            serve(eg, who, lat, p, id, to);
            checks++;
            if (to || who !== eg || id !== eg || p !== pa[eg] * pb[eg] || lat !== exp_lat(pa[eg], pb[eg])) begin
                errors++;
                $display("FAIL rand%0d got who=%0d p=%0d lat=%0d exp %0d %0d %0d", it, who, p, lat,
                         eg, pa[eg] * pb[eg], exp_lat(pa[eg], pb[eg]));
            end
            pend[eg] = 1'b0;
            if (!bus.rsp_ready) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                checks++;
                if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_p) !== pa[eg] * pb[eg]) begin
                    errors++;
                    $display("FAIL rand_hold%0d got v=%b p=%0d exp 1 %0d", it, bus.rsp_valid, bus.rsp_p, pa[eg] * pb[eg]);
                end
            end
            handshake();
        end
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
    endtask

    initial begin
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b0, 0, 0);
        test_reset();
        test_max();
        test_round_robin();
        test_backpressure();
        test_reset_abort();
        test_zero();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
